wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
Single-outstanding Wishbone pipelined-mode initiator. It turns a valid/ready command stream (address, data, write enable) into one bus transaction and returns the read data or a timeout error on a valid/ready response stream. It sits between a CPU load/store unit or debug controller and the Wishbone interconnect, driving slaves such as wb_uart. It honours stall, waits for ack, and bounds every transaction with a timeout so a dead slave cannot hang the initiator.

Parameters:
ADDR_WIDTH, 32, width of i_cmd_addr and o_addr.
TIMEOUT_CYCLES, 1024, cycles from first stb assertion to forced abort; 0 disables the timeout.

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous active-high reset
i_cmd_valid  input  1  command present
o_cmd_ready  output  1  command accepted when valid&&ready
i_cmd_we  input  1  1=write, 0=read
i_cmd_addr  input  ADDR_WIDTH  target address
i_cmd_data  input  32  write data
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  response consumed when valid&&ready
o_rsp_data  output  32  read data (0 for writes and errors)
o_rsp_err  output  1  1=timeout abort
o_cyc  output  1  Wishbone cycle
o_stb  output  1  Wishbone strobe
o_we  output  1  Wishbone write enable
o_addr  output  ADDR_WIDTH  Wishbone address
o_data  output  32  Wishbone write data
i_data  input  32  Wishbone read data
i_stall  input  1  slave stall
i_ack  input  1  slave acknowledge

Behaviour:
- All outputs registered. Reset (asynchronous, takes effect immediately, including mid-transaction) sets state=IDLE; o_cyc=o_stb=o_we=0, o_addr=0, o_data=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, timeout counter=0. o_cmd_ready=1 after reset (combinational from state==IDLE).
- States: IDLE, REQ, WAIT, RESP.
- IDLE: o_cmd_ready=1. On i_cmd_valid, latch we/addr/data into o_we/o_addr/o_data, set o_cyc=o_stb=1, counter=0, go REQ.
- REQ: o_stb held with stable we/addr/data. Edge with !i_stall: o_stb<=0, o_cyc held, go WAIT. i_ack in REQ is a slave protocol violation and is ignored.
- WAIT: o_cyc=1, o_stb=0. Edge with i_ack: o_cyc<=0; o_rsp_data<=(o_we ? 0 : i_data); o_rsp_err<=0; o_rsp_valid<=1; go RESP.
- Timeout: counter increments every cycle in REQ and WAIT, saturating. When TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without i_ack this cycle: o_cyc<=0, o_stb<=0, o_rsp_data<=0, o_rsp_err<=1, o_rsp_valid<=1, go RESP. i_ack in the same cycle wins, giving a normal response. Counter width is clog2(TIMEOUT_CYCLES+1).
- RESP: o_rsp_valid held with data/err stable until i_rsp_ready. On that edge o_rsp_valid<=0 and the state goes to IDLE. No new command is accepted in the same cycle, so there is at least one IDLE cycle between transactions.
- Latency with no stall and a slave that acks one cycle after stb (as wb_uart does): command handshake at edge N, stb high N..N+1, ack sampled at edge N+2, o_rsp_valid high after N+2. Each stall cycle adds one cycle.
- o_cyc falls only on the ack or timeout edge and never while o_stb=1 except on abort. o_stb never reasserts within one o_cyc. At most one transaction is outstanding.
- i_cmd_* are ignored outside IDLE. i_data is sampled only on the ack edge.

Test Plan:
- Write with no stall: cmd we=1 addr=0x10 data=0x41. Expect 1 cycle o_stb=1 with o_data=0x41 and o_we=1, then o_cyc=1/o_stb=0 until ack. o_rsp_valid after edge N+2 with err=0 and data=0.
- Read: slave returns i_data=0x0000_005A on ack. Expect o_rsp_data=0x5A, err=0. Hold i_rsp_ready=0 for 5 cycles: o_rsp_valid and data stay stable, o_cmd_ready=0.
- Stall: i_stall=1 for 3 cycles. o_stb, o_addr, o_data and o_we stay stable for 4 cycles, stb drops on the first !stall edge, and the response is 3 cycles later than in the no-stall case.
- Timeout: TIMEOUT_CYCLES=8, slave never acks. o_cyc drops after exactly 8 cycles of o_cyc, then o_rsp_valid=1, o_rsp_err=1, o_rsp_data=0. The next command proceeds normally.
- Ack on the timeout cycle: TIMEOUT_CYCLES=8 with ack in the 8th cycle. Expect a normal response with err=0 and the returned data.
- Async reset mid-WAIT: assert i_rst between clock edges. o_cyc, o_stb and o_rsp_valid go to 0 before the next edge. After release o_cmd_ready=1 and a late i_ack is ignored.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus
// transaction out, one response (read data or timeout error) back.
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]           i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_cyc,
    output logic                  o_stb,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [31:0]           o_data,
    input  logic [31:0]           i_data,
    input  logic                  i_stall,
    input  logic                  i_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    cyc_reg, cyc_next;
    logic                    stb_reg, stb_next;
    logic                    we_reg, we_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [31:0]             data_reg, data_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [31:0]             rsp_data_reg, rsp_data_next;
    logic                    rsp_err_reg, rsp_err_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    timeout_hit;
    logic [CNT_W-1:0]        cnt_sat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= S_IDLE;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            stb_reg       <= stb_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cyc_next       = cyc_reg;
        stb_next       = stb_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        data_next      = data_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        cnt_next       = cnt_reg;
        timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);
        cnt_sat        = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    we_next    = i_cmd_we;
                    addr_next  = i_cmd_addr;
                    data_next  = i_cmd_data;
                    cyc_next   = 1'b1;
                    stb_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                cnt_next = cnt_sat;
                // An ack here is a slave protocol violation, so it cannot rescue a timeout.
                if (timeout_hit) begin
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    rsp_data_next  = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RESP;
                end else if (!i_stall) begin
                    stb_next   = 1'b0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_sat;
                if (i_ack) begin
                    cyc_next       = 1'b0;
                    rsp_data_next  = we_reg ? 32'd0 : i_data;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RESP;
                end else if (timeout_hit) begin
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    rsp_data_next  = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign o_cmd_ready = (state_reg == S_IDLE);
    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_data  = rsp_data_reg;
    assign o_rsp_err   = rsp_err_reg;
    assign o_cyc       = cyc_reg;
    assign o_stb       = stb_reg;
    assign o_we        = we_reg;
    assign o_addr      = addr_reg;
    assign o_data      = data_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master with an 8-cycle timeout.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        cyc, stb, we;
    logic [31:0] addr, wdata, rdata;
    logic        stall, ack;

    int n_checks = 0;
    int n_pass   = 0;

    wb_cmd_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_cyc       (cyc),
        .o_stb       (stb),
        .o_we        (we),
        .o_addr      (addr),
        .o_data      (wdata),
        .i_data      (rdata),
        .i_stall     (stall),
        .i_ack       (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one edge; DUT is expected to be idle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_data = d;
        tick();
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_data = 32'hFFFF_FFFF;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consume_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("consume_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; rdata = '0; stall = 1'b0; ack = 1'b0;
        tick(); tick();
        chk("rst_cyc",       {31'd0, cyc},       32'd0);
        chk("rst_stb",       {31'd0, stb},       32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_addr",      addr,               32'd0);
        rst = 1'b0;
        tick();

        // Write, no stall, ack one cycle after stb
        issue(1'b1, 32'h10, 32'h41);
        chk("wr_stb",       {31'd0, stb},       32'd1);
        chk("wr_cyc",       {31'd0, cyc},       32'd1);
        chk("wr_we",        {31'd0, we},        32'd1);
        chk("wr_addr",      addr,               32'h10);
        chk("wr_data",      wdata,              32'h41);
        chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("wr_wait_stb",  {31'd0, stb},       32'd0);
        chk("wr_wait_cyc",  {31'd0, cyc},       32'd1);
        chk("wr_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0; rdata = 32'd0;
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("wr_rsp_data",  rsp_data,           32'd0);
        chk("wr_cyc_drop",  {31'd0, cyc},       32'd0);
        consume();
        $display("txn write addr=0x10 data=0x41 done");

        // Read with back-pressure on the response
        issue(1'b0, 32'h20, 32'h0);
        chk("rd_we", {31'd0, we}, 32'd0);
        tick();
        ack = 1'b1; rdata = 32'h0000_005A;
        tick();
        ack = 1'b0; rdata = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rd_hold_data",  rsp_data,           32'h5A);
            chk("rd_hold_err",   {31'd0, rsp_err},   32'd0);
            chk("rd_hold_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        consume();
        $display("txn read addr=0x20 data=0x5A done");

        // Stall for 3 cycles
        stall = 1'b1;
        issue(1'b1, 32'h30, 32'h77);
        for (int i = 0; i < 3; i++) begin
            chk("st_stb",  {31'd0, stb}, 32'd1);
            chk("st_addr", addr,         32'h30);
            chk("st_data", wdata,        32'h77);
            chk("st_we",   {31'd0, we},  32'd1);
            tick();
        end
        chk("st_stb_last", {31'd0, stb}, 32'd1);
        stall = 1'b0;
        tick();
        chk("st_stb_drop", {31'd0, stb},       32'd0);
        chk("st_cyc_held", {31'd0, cyc},       32'd1);
        chk("st_no_rsp",   {31'd0, rsp_valid}, 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("st_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("st_rsp_err",   {31'd0, rsp_err},   32'd0);
        consume();
        $display("txn stalled write addr=0x30 data=0x77 done");

        // Timeout: slave never acks, cyc high for exactly 8 cycles
        rdata = 32'h0BAD_0BAD;
        issue(1'b0, 32'h40, 32'h0);
        for (int i = 1; i < 8; i++) begin
            chk("to_cyc_high", {31'd0, cyc},       32'd1);
            chk("to_no_rsp",   {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        chk("to_cyc_8th", {31'd0, cyc}, 32'd1);
        tick();
        chk("to_cyc_drop",  {31'd0, cyc},       32'd0);
        chk("to_stb_drop",  {31'd0, stb},       32'd0);
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_err",   {31'd0, rsp_err},   32'd1);
        chk("to_rsp_data",  rsp_data,           32'd0);
        consume();
        $display("txn read addr=0x40 timed out");

        // Next command after a timeout proceeds normally
        issue(1'b0, 32'h44, 32'h0);
        tick();
        ack = 1'b1; rdata = 32'hCAFE_0001;
        tick();
        ack = 1'b0;
        chk("post_to_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_to_err",   {31'd0, rsp_err},   32'd0);
        chk("post_to_data",  rsp_data,           32'hCAFE_0001);
        consume();
        $display("txn read addr=0x44 after timeout done");

        // Ack arriving on the 8th (timeout) cycle wins
        issue(1'b0, 32'h50, 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("ta_cyc_high", {31'd0, cyc}, 32'd1);
            tick();
        end
        ack = 1'b1; rdata = 32'h1234_5678;
        tick();
        ack = 1'b0;
        chk("ta_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ta_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("ta_rsp_data",  rsp_data,           32'h1234_5678);
        consume();
        $display("txn read addr=0x50 ack on timeout cycle done");

        // Asynchronous reset while waiting for ack
        issue(1'b0, 32'h60, 32'h0);
        tick();
        chk("ar_in_wait", {31'd0, cyc}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_cyc",       {31'd0, cyc},       32'd0);
        chk("ar_stb",       {31'd0, stb},       32'd0);
        chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0; ack = 1'b1; rdata = 32'h7777_7777;
        tick();
        ack = 1'b0;
        chk("ar_cmd_ready",  {31'd0, cmd_ready}, 32'd1);
        chk("ar_late_ack",   {31'd0, rsp_valid}, 32'd0);
        chk("ar_cyc_after",  {31'd0, cyc},       32'd0);
        $display("txn read addr=0x60 aborted by reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
